// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator/checker pair: FSM states,
// default data width and status-flag bit positions.
package lfsr_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int FLAG_LOCKUP  = 0;
  localparam int FLAG_TIMEOUT = 1;
  localparam int NUM_FLAGS    = 2;

endpackage

// File: rtl/lfsr_period_meter_if.sv
// Measurement request / sample stream / result bundle of lfsr_period_meter.
// master drives requests and samples; slave is the meter.
interface lfsr_period_meter_if #(
  parameter int WIDTH = lfsr_pkg::WIDTH_DEF,
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             en_i;
  logic [WIDTH-1:0] val_i;
  logic [WIDTH-1:0] data_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] period_o;
  logic             lockup_o;
  logic             timeout_o;

  modport master (
    output start_i, en_i, val_i, data_i,
    input  busy_o, done_o, period_o, lockup_o, timeout_o
  );

  modport slave (
    input  start_i, en_i, val_i, data_i,
    output busy_o, done_o, period_o, lockup_o, timeout_o
  );
endinterface

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: rise_o is high while d_i=1 and its registered copy is 0.
module edge_detect_rise (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/lfsr_period_meter.sv
// Counts enabled LFSR samples until the captured seed recurs; reports the
// period, or flags an all-zero lockup or a terminal-count timeout.
module lfsr_period_meter
  import lfsr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  lfsr_period_meter_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 first_q, first_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 start_rise_s;
  logic [CNT_W-1:0]     k_s;

  edge_detect_rise u_start_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (bus.start_i),
    .rise_o (start_rise_s)
  );

  // Index of the sample being compared; cnt_q never reaches CNT_MAX, so no wrap.
  assign k_s = cnt_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    period_d = period_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise_s) begin
          ref_d    = bus.val_i;
          cnt_d    = {CNT_W{1'b0}};
          first_d  = 1'b1;
          period_d = {CNT_W{1'b0}};
          flags_d  = {NUM_FLAGS{1'b0}};
          state_d  = ST_COUNT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_COUNT: begin
        // Abort outranks any same-cycle termination; lockup outranks match/timeout.
        if (!bus.start_i) begin
          state_d = ST_IDLE;
        end else if (!bus.en_i) begin
          state_d = ST_COUNT;
        end else if (first_q) begin
          first_d = 1'b0;
        end else if (bus.data_i == {WIDTH{1'b0}}) begin
          flags_d[FLAG_LOCKUP] = 1'b1;
          period_d             = k_s;
          state_d              = ST_DONE;
        end else if (bus.data_i == ref_q) begin
          period_d = k_s;
          state_d  = ST_DONE;
        end else if (k_s == CNT_MAX) begin
          flags_d[FLAG_TIMEOUT] = 1'b1;
          period_d              = k_s;
          state_d               = ST_DONE;
        end else begin
          cnt_d = k_s;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_COUNT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      ref_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      first_q  <= 1'b0;
      period_q <= {CNT_W{1'b0}};
      flags_q  <= {NUM_FLAGS{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      period_q <= period_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.period_o  = period_q;
  assign bus.lockup_o  = flags_q[FLAG_LOCKUP];
  assign bus.timeout_o = flags_q[FLAG_TIMEOUT];
endmodule

// File: tb/tb_lfsr_period_meter.sv
// Bench for lfsr_period_meter: directed vector table, randomized runs against
// a rule-level reference model, an LFSR-driven loop and async reset checks.
module tb_lfsr_period_meter;
  logic clk;
  logic rst_n;

  lfsr_period_meter_if #(.WIDTH(8), .CNT_W(16)) b0 ();
  lfsr_period_meter_if #(.WIDTH(8), .CNT_W(4))  b4 ();

  lfsr_period_meter #(.WIDTH(8), .CNT_W(16)) dut0 (.clk_i(clk), .rst_i(rst_n), .bus(b0));
  lfsr_period_meter #(.WIDTH(8), .CNT_W(4))  dut4 (.clk_i(clk), .rst_i(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [7:0] stim_d  [0:399];
  logic       stim_en [0:399];
  logic       stim_st [0:399];
  int         stim_n;

  int obs_busy, obs_dcnt, obs_didx, obs_per, obs_lk, obs_to;

  typedef struct packed {
    logic             sel;
    logic [7:0]       seed;
    logic [4:0]       n;
    logic [0:15][7:0] data;
    logic [15:0]      en;
    logic [15:0]      st;
    int               per;
    int               lk;
    int               to;
    int               didx;
    int               busy;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drv(input bit sel, input logic st, input logic en, input logic [7:0] d, input logic [7:0] seed);
    if (sel) begin
      b4.start_i = st; b4.en_i = en; b4.data_i = d; b4.val_i = seed;
      b0.start_i = 1'b0; b0.en_i = 1'b0;
    end else begin
      b0.start_i = st; b0.en_i = en; b0.data_i = d; b0.val_i = seed;
      b4.start_i = 1'b0; b4.en_i = 1'b0;
    end
  endtask

  task automatic samp(input bit sel, output int bsy, output int dn, output int per, output int lk, output int to);
    if (sel) begin
      bsy = int'(b4.busy_o); dn = int'(b4.done_o); per = int'(b4.period_o);
      lk = int'(b4.lockup_o); to = int'(b4.timeout_o);
    end else begin
      bsy = int'(b0.busy_o); dn = int'(b0.done_o); per = int'(b0.period_o);
      lk = int'(b0.lockup_o); to = int'(b0.timeout_o);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rise edge is observation 0; stimulus sample i is observation i+1; then 4 drain cycles.
  task automatic run(input bit sel, input logic [7:0] seed);
    int bsy, dn, per, lk, to;
    obs_busy = 0; obs_dcnt = 0; obs_didx = -1;
    for (int i = 0; i <= stim_n + 4; i++) begin
      if (i == 0)
        drv(sel, 1'b1, 1'b0, 8'h00, seed);
      else if (i <= stim_n)
        drv(sel, stim_st[i-1], stim_en[i-1], stim_d[i-1], seed);
      else
        drv(sel, stim_st[stim_n-1], 1'b0, stim_d[stim_n-1], seed);
      tick();
      samp(sel, bsy, dn, per, lk, to);
      obs_busy += bsy;
      if (dn != 0) begin
        obs_dcnt++;
        if (obs_didx < 0) obs_didx = i;
      end
    end
    obs_per = per; obs_lk = lk; obs_to = to;
  endtask

  // Scan the stimulus by the measurement rules: first enabled sample is the
  // seed, later ones numbered k; abort wins, then zero, seed, terminal count.
  task automatic model(input bit sel, input logic [7:0] seed,
                       output int e_per, output int e_lk, output int e_to,
                       output int e_didx, output int e_busy);
    int  maxk;
    int  k;
    bit  seen_first;
    maxk = sel ? 15 : 65535;
    k = 0; seen_first = 1'b0;
    e_per = 0; e_lk = 0; e_to = 0; e_didx = -1;
    e_busy = stim_n + 5;
    for (int i = 0; i < stim_n; i++) begin
      if (!stim_st[i]) begin
        e_busy = i + 1;
        return;
      end
      if (stim_en[i]) begin
        if (!seen_first) begin
          seen_first = 1'b1;
        end else begin
          k++;
          if (stim_d[i] == 8'h00 || stim_d[i] == seed || k == maxk) begin
            e_per  = k;
            e_lk   = (stim_d[i] == 8'h00) ? 1 : 0;
            e_to   = (e_lk == 0 && stim_d[i] != seed) ? 1 : 0;
            e_didx = i + 1;
            e_busy = i + 1;
            return;
          end
        end
      end
    end
  endtask

  task automatic idle_and_check_hold(input bit sel, input string tag, input int per, input int lk, input int to);
    int bsy, dn, p, l, t;
    drv(sel, 1'b0, 1'b0, 8'h00, 8'h00);
    tick(); tick();
    samp(sel, bsy, dn, p, l, t);
    chk({tag, "_hold_period"}, p, per);
    chk({tag, "_hold_lockup"}, l, lk);
    chk({tag, "_hold_timeout"}, t, to);
    chk({tag, "_idle_busy"}, bsy, 0);
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic setv(input int v, input bit sel, input logic [7:0] seed, input int n,
                      input logic [15:0] en, input logic [15:0] st, input int per,
                      input int lk, input int to, input int didx, input int busy);
    tv[v].sel = sel; tv[v].seed = seed; tv[v].n = 5'(n);
    tv[v].data = '0; tv[v].en = en; tv[v].st = st;
    tv[v].per = per; tv[v].lk = lk; tv[v].to = to; tv[v].didx = didx; tv[v].busy = busy;
  endtask

  task automatic load_vec(input int v);
    stim_n = int'(tv[v].n);
    for (int j = 0; j < stim_n; j++) begin
      stim_d[j]  = tv[v].data[j];
      stim_en[j] = tv[v].en[j];
      stim_st[j] = tv[v].st[j];
    end
  endtask

  initial begin
    int bsy, dn, p, l, t;
    int e_per, e_lk, e_to, e_didx, e_busy;
    int cyc;
    logic [7:0] x, sd;
    bit sel;
    n_cmp = 0; n_bad = 0;

    setv(0,  1'b0, 8'hF0, 5,  16'h001F, 16'h001F, 4,  0, 0, 5,  5);
    tv[0].data[0] = 8'hF0; tv[0].data[1] = 8'h11; tv[0].data[2] = 8'h22;
    tv[0].data[3] = 8'h33; tv[0].data[4] = 8'hF0;
    setv(1,  1'b0, 8'hF0, 8,  16'h00C7, 16'h00FF, 4,  0, 0, 8,  8);
    tv[1].data[0] = 8'hF0; tv[1].data[1] = 8'h11;
    for (int j = 2; j < 6; j++) tv[1].data[j] = 8'h22;
    tv[1].data[6] = 8'h33; tv[1].data[7] = 8'hF0;
    setv(2,  1'b0, 8'hF0, 3,  16'h0007, 16'h0007, 2,  1, 0, 3,  3);
    tv[2].data[0] = 8'hF0; tv[2].data[1] = 8'h5A; tv[2].data[2] = 8'h00;
    setv(3,  1'b0, 8'h00, 2,  16'h0003, 16'h0003, 1,  1, 0, 2,  2);
    setv(4,  1'b1, 8'hF0, 16, 16'hFFFF, 16'hFFFF, 15, 0, 1, 16, 16);
    setv(5,  1'b1, 8'hF0, 16, 16'hFFFF, 16'hFFFF, 15, 1, 0, 16, 16);
    setv(6,  1'b1, 8'hF0, 16, 16'hFFFF, 16'hFFFF, 15, 0, 0, 16, 16);
    for (int j = 1; j < 16; j++) begin
      tv[4].data[j] = 8'(j); tv[5].data[j] = 8'(j); tv[6].data[j] = 8'(j);
    end
    tv[4].data[0] = 8'hF0; tv[5].data[0] = 8'hF0; tv[6].data[0] = 8'hF0;
    tv[5].data[15] = 8'h00; tv[6].data[15] = 8'hF0;
    setv(7,  1'b0, 8'hF0, 2,  16'h0003, 16'h0003, 1,  0, 0, 2,  2);
    tv[7].data[0] = 8'hF0; tv[7].data[1] = 8'hF0;
    setv(8,  1'b0, 8'hF0, 2,  16'h0003, 16'h0003, 1,  0, 0, 2,  2);
    tv[8].data[1] = 8'hF0;
    setv(9,  1'b0, 8'hF0, 4,  16'h000F, 16'h0007, 0,  0, 0, -1, 4);
    tv[9].data[0] = 8'hF0; tv[9].data[1] = 8'h11; tv[9].data[2] = 8'h22; tv[9].data[3] = 8'h33;
    setv(10, 1'b0, 8'hF0, 3,  16'h0007, 16'h0003, 0,  0, 0, -1, 3);
    tv[10].data[0] = 8'hF0; tv[10].data[1] = 8'h11; tv[10].data[2] = 8'hF0;

    rst_n = 1'b0;
    b0.start_i = 1'b0; b0.en_i = 1'b0; b0.val_i = 8'h00; b0.data_i = 8'h00;
    b4.start_i = 1'b0; b4.en_i = 1'b0; b4.val_i = 8'h00; b4.data_i = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    samp(1'b0, bsy, dn, p, l, t);
    chk("reset_busy", bsy, 0); chk("reset_done", dn, 0); chk("reset_period", p, 0);
    chk("reset_lockup", l, 0); chk("reset_timeout", t, 0);

    for (int v = 0; v < 11; v++) begin
      load_vec(v);
      run(tv[v].sel, tv[v].seed);
      chk($sformatf("vec%0d_period", v), obs_per, tv[v].per);
      chk($sformatf("vec%0d_lockup", v), obs_lk, tv[v].lk);
      chk($sformatf("vec%0d_timeout", v), obs_to, tv[v].to);
      chk($sformatf("vec%0d_done_at", v), obs_didx, tv[v].didx);
      chk($sformatf("vec%0d_done_pulses", v), obs_dcnt, (tv[v].didx < 0) ? 0 : 1);
      chk($sformatf("vec%0d_busy_cycles", v), obs_busy, tv[v].busy);
      idle_and_check_hold(tv[v].sel, $sformatf("vec%0d", v), tv[v].per, tv[v].lk, tv[v].to);
    end

    for (int r = 0; r < 30; r++) begin
      sel = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      stim_n = $urandom_range(3, 40);
      for (int j = 0; j < stim_n; j++) begin
        int c;
        c = $urandom_range(0, 19);
        stim_en[j] = ($urandom_range(0, 9) < 7);
        stim_d[j]  = (c == 0) ? 8'h00 : (c < 3) ? sd : 8'($urandom);
        stim_st[j] = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) begin
        int a;
        a = $urandom_range(1, stim_n - 1);
        for (int j = a; j < stim_n; j++) stim_st[j] = 1'b0;
      end
      stim_st[stim_n-1] = 1'b0;
      model(sel, sd, e_per, e_lk, e_to, e_didx, e_busy);
      run(sel, sd);
      chk($sformatf("rnd%0d_period", r), obs_per, e_per);
      chk($sformatf("rnd%0d_lockup", r), obs_lk, e_lk);
      chk($sformatf("rnd%0d_timeout", r), obs_to, e_to);
      chk($sformatf("rnd%0d_done_at", r), obs_didx, e_didx);
      chk($sformatf("rnd%0d_done_pulses", r), obs_dcnt, (e_didx < 0) ? 0 : 1);
      chk($sformatf("rnd%0d_busy_cycles", r), obs_busy, e_busy);
      idle_and_check_hold(sel, $sformatf("rnd%0d", r), e_per, e_lk, e_to);
    end

    // LFSR loop: cycle length found by stepping the polynomial from the seed.
    sd = 8'hF0;
    cyc = 1;
    x = lfsr_step(sd);
    while (x != sd && cyc < 1000) begin
      x = lfsr_step(x);
      cyc++;
    end
    x = sd;
    stim_n = 400;
    for (int j = 0; j < stim_n; j++) begin
      stim_en[j] = (j >= 100) || ($urandom_range(0, 7) != 0);
      stim_d[j]  = x;
      stim_st[j] = 1'b1;
      if (stim_en[j]) x = lfsr_step(x);
    end
    model(1'b0, sd, e_per, e_lk, e_to, e_didx, e_busy);
    run(1'b0, sd);
    chk("lfsr_period", obs_per, cyc);
    chk("lfsr_lockup", obs_lk, 0);
    chk("lfsr_done_pulses", obs_dcnt, 1);
    chk("lfsr_done_at", obs_didx, e_didx);
    idle_and_check_hold(1'b0, "lfsr", cyc, 0, 0);

    // Async reset: dut4 idles holding a timeout, dut0 is mid-count.
    load_vec(4);
    run(1'b1, 8'hF0);
    idle_and_check_hold(1'b1, "pre_rst", 15, 0, 1);
    drv(1'b0, 1'b1, 1'b0, 8'h00, 8'hF0); tick();
    drv(1'b0, 1'b1, 1'b1, 8'hF0, 8'hF0); tick();
    drv(1'b0, 1'b1, 1'b1, 8'h11, 8'hF0); tick();
    samp(1'b0, bsy, dn, p, l, t);
    chk("mid_count_busy", bsy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    samp(1'b0, bsy, dn, p, l, t);
    chk("arst_busy", bsy, 0); chk("arst_done", dn, 0); chk("arst_period", p, 0);
    samp(1'b1, bsy, dn, p, l, t);
    chk("arst_idle_timeout", t, 0); chk("arst_idle_period", p, 0);
    drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    samp(1'b0, bsy, dn, p, l, t);
    chk("post_rst_busy", bsy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
